// File: rtl/mem_port_arbiter_if.sv
// Fetch, data and shared memory port bundle for mem_port_arbiter; the arbiter uses
// the slave view, the core/memory environment the master view.
interface mem_port_arbiter_if #(
  parameter int AW = 32,
  parameter int DW = 32
);
  logic          i_req;
  logic [AW-1:0] i_addr;
  logic [DW-1:0] i_rdata;
  logic          i_ready;
  logic          d_req;
  logic          d_we;
  logic [AW-1:0] d_addr;
  logic [DW-1:0] d_wdata;
  logic [DW-1:0] d_rdata;
  logic          d_ready;
  logic          m_req;
  logic          m_we;
  logic [AW-1:0] m_addr;
  logic [DW-1:0] m_wdata;
  logic [DW-1:0] m_rdata;
  logic          m_ack;
  logic          err;

  modport slave (
    input  i_req, i_addr, d_req, d_we, d_addr, d_wdata, m_rdata, m_ack,
    output i_rdata, i_ready, d_rdata, d_ready, m_req, m_we, m_addr, m_wdata, err
  );

  modport master (
    output i_req, i_addr, d_req, d_we, d_addr, d_wdata, m_rdata, m_ack,
    input  i_rdata, i_ready, d_rdata, d_ready, m_req, m_we, m_addr, m_wdata, err
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// Shares one memory port between fetch and data; ready pulses the cycle after m_ack (>=2 edges
// from request), cores stall while ready is low. Optional m_ack timeout: MEM_ARB_TIMEOUT_EN.
module mem_port_arbiter #(
  parameter int AW      = 32,
  parameter int DW      = 32,
  parameter int TIMEOUT = 255
) (
  input  logic              clk,
  input  logic              reset,
  mem_port_arbiter_if.slave bus
);
  typedef enum logic [1:0] {ST_IDLE, ST_BUSY, ST_RESP} state_t;

  state_t        r_state, w_state;
  logic          r_m_req, w_m_req;
  logic          r_m_we, w_m_we;
  logic [AW-1:0] r_m_addr, w_m_addr;
  logic [DW-1:0] r_m_wdata, w_m_wdata;
  logic [DW-1:0] r_i_rdata, w_i_rdata;
  logic [DW-1:0] r_d_rdata, w_d_rdata;
  logic          r_i_ready, w_i_ready;
  logic          r_d_ready, w_d_ready;
  // owner / last grant: 1 = data port, 0 = fetch port
  logic          r_owner_d, w_owner_d;
  logic          r_last_d, w_last_d;
  logic          w_grant_d;
  logic          w_abort;
`ifdef MEM_ARB_TIMEOUT_EN
  localparam logic [7:0] TO_LAST = 8'(TIMEOUT - 1);
  logic [7:0]    r_cnt, w_cnt;
  logic          r_err, w_err;
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_m_req   <= 1'b0;
      r_m_we    <= 1'b0;
      r_m_addr  <= '0;
      r_m_wdata <= '0;
      r_i_rdata <= '0;
      r_d_rdata <= '0;
      r_i_ready <= 1'b0;
      r_d_ready <= 1'b0;
      r_owner_d <= 1'b0;
      r_last_d  <= 1'b0;
`ifdef MEM_ARB_TIMEOUT_EN
      r_cnt     <= '0;
      r_err     <= 1'b0;
`endif
    end else begin
      r_m_req   <= w_m_req;
      r_m_we    <= w_m_we;
      r_m_addr  <= w_m_addr;
      r_m_wdata <= w_m_wdata;
      r_i_rdata <= w_i_rdata;
      r_d_rdata <= w_d_rdata;
      r_i_ready <= w_i_ready;
      r_d_ready <= w_d_ready;
      r_owner_d <= w_owner_d;
      r_last_d  <= w_last_d;
`ifdef MEM_ARB_TIMEOUT_EN
      r_cnt     <= w_cnt;
      r_err     <= w_err;
`endif
    end
  end

  always_comb begin
    w_state   = r_state;
    w_m_req   = r_m_req;
    w_m_we    = r_m_we;
    w_m_addr  = r_m_addr;
    w_m_wdata = r_m_wdata;
    w_i_rdata = r_i_rdata;
    w_d_rdata = r_d_rdata;
    w_i_ready = 1'b0;
    w_d_ready = 1'b0;
    w_owner_d = r_owner_d;
    w_last_d  = r_last_d;
    w_abort   = 1'b0;
    // on conflict the port that was not served last wins
    w_grant_d = bus.d_req && (!bus.i_req || !r_last_d);
`ifdef MEM_ARB_TIMEOUT_EN
    w_cnt     = r_cnt;
    w_err     = r_err;
`endif
    case (r_state)
      ST_IDLE: begin
        if (bus.i_req || bus.d_req) begin
          w_state   = ST_BUSY;
          w_m_req   = 1'b1;
          w_owner_d = w_grant_d;
          w_m_addr  = w_grant_d ? bus.d_addr : bus.i_addr;
          w_m_we    = w_grant_d && bus.d_we;
          if (w_grant_d) w_m_wdata = bus.d_wdata;
`ifdef MEM_ARB_TIMEOUT_EN
          w_cnt     = '0;
`endif
        end
      end
      ST_BUSY: begin
`ifdef MEM_ARB_TIMEOUT_EN
        if (!bus.m_ack) begin
          w_cnt   = r_cnt + 8'd1;
          w_abort = (r_cnt == TO_LAST);
        end
`endif
        if (bus.m_ack || w_abort) begin
          w_state   = ST_RESP;
          w_m_req   = 1'b0;
          w_m_we    = 1'b0;
          w_last_d  = r_owner_d;
          w_i_ready = !r_owner_d;
          w_d_ready = r_owner_d;
          if (w_abort) begin
`ifdef MEM_ARB_TIMEOUT_EN
            w_err = 1'b1;
`endif
            if (r_owner_d) w_d_rdata = DW'(32'hDEAD_BEEF);
            else           w_i_rdata = DW'(32'hDEAD_BEEF);
          end else if (!r_m_we) begin
            if (r_owner_d) w_d_rdata = bus.m_rdata;
            else           w_i_rdata = bus.m_rdata;
          end
        end
      end
      ST_RESP: w_state = ST_IDLE;
      default: w_state = ST_IDLE;
    endcase
  end

  assign bus.m_req   = r_m_req;
  assign bus.m_we    = r_m_we;
  assign bus.m_addr  = r_m_addr;
  assign bus.m_wdata = r_m_wdata;
  assign bus.i_rdata = r_i_rdata;
  assign bus.d_rdata = r_d_rdata;
  assign bus.i_ready = r_i_ready;
  assign bus.d_ready = r_d_ready;
`ifdef MEM_ARB_TIMEOUT_EN
  assign bus.err     = r_err;
`else
  assign bus.err     = 1'b0;
`endif
endmodule
